opcode_demux: RTL and testbench

//   Receives one stream of sprite opcodes {ADDR, ID_CODE, X, Y} plus a destination select.

---
 rtl/opcode_pkg.sv | 25 ++
 rtl/opcode_fifo.sv | 57 +++++
 rtl/opcode_demux.sv | 92 +++++++++
 tb/tb_opcode_demux.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_pkg.sv
// Shared opcode types and field widths for the sprite opcode demux.
package opcode_pkg;

    localparam int ADDR_W  = 2;
    localparam int ID_W    = 2;
    localparam int COORD_W = 9;

    // Destination select values carried alongside each stored opcode
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [ID_W-1:0]    id_code;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } opcode_t;

    // One FIFO slot: destination select in the MSB, opcode fields below it
    typedef struct packed {
        logic    sel;
        opcode_t op;
    } entry_t;

endpackage

// File: rtl/opcode_fifo.sv
// Synchronous FIFO: storage, wrap-around pointers and occupancy count.
module opcode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards every stored entry
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly PTR_W bits, so +1 wraps at DEPTH on its own
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an empty count already hides stale contents.
        if (!reset && push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/opcode_demux.sv
// Buffers sprite opcodes and delivers each, strictly in order, to sink A or sink B.
module opcode_demux
    import opcode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sel,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [ID_W-1:0]         in_id_code,
    input  logic [COORD_W-1:0]      in_x,
    input  logic [COORD_W-1:0]      in_y,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic [ADDR_W-1:0]       a_addr,
    output logic [ID_W-1:0]         a_id_code,
    output logic [COORD_W-1:0]      a_x,
    output logic [COORD_W-1:0]      a_y,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ADDR_W-1:0]       b_addr,
    output logic [ID_W-1:0]         b_id_code,
    output logic [COORD_W-1:0]      b_x,
    output logic [COORD_W-1:0]      b_y,
    output logic [$clog2(DEPTH):0]  count
);

    entry_t  wentry;
    entry_t  head;
    opcode_t a_op;
    opcode_t b_op;
    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    head_valid;

    assign wentry = '{sel: in_sel,
                      op:  '{addr: in_addr, id_code: in_id_code, x: in_x, y: in_y}};

    // No pass-through: a full FIFO refuses input even when it pops this cycle
    assign in_ready   = !reset && !full;
    assign push       = in_valid && in_ready;
    assign head_valid = !reset && !empty;
    assign pop        = (a_valid && a_ready) || (b_valid && b_ready);

    opcode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Route the head entry to exactly one sink; the idle sink sees all-zero data
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_op    = '0;
        b_op    = '0;
        if (head_valid) begin
            if (head.sel == SEL_A) begin
                a_valid = 1'b1;
                a_op    = head.op;
            end else begin
                b_valid = 1'b1;
                b_op    = head.op;
            end
        end
    end

    assign a_addr    = a_op.addr;
    assign a_id_code = a_op.id_code;
    assign a_x       = a_op.x;
    assign a_y       = a_op.y;
    assign b_addr    = b_op.addr;
    assign b_id_code = b_op.id_code;
    assign b_x       = b_op.x;
    assign b_y       = b_op.y;

endmodule

// File: tb/tb_opcode_demux.sv
// Directed bench for opcode_demux with an in-order scoreboard on both sinks.
module tb_opcode_demux;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [1:0] in_addr;
    logic [1:0] in_id_code;
    logic [8:0] in_x;
    logic [8:0] in_y;
    logic       a_valid, a_ready;
    logic [1:0] a_addr, a_id_code;
    logic [8:0] a_x, a_y;
    logic       b_valid, b_ready;
    logic [1:0] b_addr, b_id_code;
    logic [8:0] b_x, b_y;
    logic [2:0] count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_delivered = 0;
    logic [22:0] sb_q[$];

    opcode_demux #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_addr    (in_addr),
        .in_id_code (in_id_code),
        .in_x       (in_x),
        .in_y       (in_y),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_id_code  (a_id_code),
        .a_x        (a_x),
        .a_y        (a_y),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_id_code  (b_id_code),
        .b_x        (b_x),
        .b_y        (b_y),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the current opcode until the demux takes it, then drop in_valid
    task automatic wait_accept(input string tag);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 50);
        check({tag, "_accept"}, acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic sel, input logic [1:0] addr, input logic [1:0] id,
                        input logic [8:0] x, input logic [8:0] y);
        in_sel     = sel;
        in_addr    = addr;
        in_id_code = id;
        in_x       = x;
        in_y       = y;
        in_valid   = 1'b1;
        wait_accept("send");
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (count != 0 && k < 50) begin
            step();
            k++;
        end
        check({tag, "_drained"}, count, 0);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    // Scoreboard: pop and compare on every sink handshake, record every accepted opcode
    always @(negedge clk) begin
        logic [22:0] e;
        check("one_hot_valid", a_valid && b_valid, 1'b0);
        if (a_valid && a_ready) begin
            n_delivered++;
            if (sb_q.size() == 0) check("a_spurious", 1'b1, 1'b0);
            else begin
                e = sb_q.pop_front();
                check("a_route", e[22], 1'b0);
                check("a_data", {a_addr, a_id_code, a_x, a_y}, e[21:0]);
            end
        end
        if (b_valid && b_ready) begin
            n_delivered++;
            if (sb_q.size() == 0) check("b_spurious", 1'b1, 1'b0);
            else begin
                e = sb_q.pop_front();
                check("b_route", e[22], 1'b1);
                check("b_data", {b_addr, b_id_code, b_x, b_y}, e[21:0]);
            end
        end
        if (!a_valid) check("a_idle_zero", {a_addr, a_id_code, a_x, a_y}, 0);
        if (!b_valid) check("b_idle_zero", {b_addr, b_id_code, b_x, b_y}, 0);
        if (in_valid && in_ready)
            sb_q.push_back({in_sel, in_addr, in_id_code, in_x, in_y});
    end

    initial begin
        int d0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_addr    = '0;
        in_id_code = '0;
        in_x       = '0;
        in_y       = '0;
        a_ready    = 1'b0;
        b_ready    = 1'b0;

        // 1: two reset cycles
        step();
        check("rst1_in_ready", in_ready, 1'b0);
        check("rst1_count", count, 0);
        step();
        check("rst2_in_ready", in_ready, 1'b0);
        check("rst2_valids", {a_valid, b_valid}, 2'b00);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_count", count, 0);
        check("post_rst_valids", {a_valid, b_valid}, 2'b00);

        // 2: single opcode to A, one-cycle latency
        a_ready = 1'b1;
        send(1'b0, 2'd2, 2'd1, 9'd100, 9'd200);
        check("lat_a_valid", a_valid, 1'b1);
        check("lat_a_x", a_x, 100);
        check("lat_a_y", a_y, 200);
        check("lat_a_addr", a_addr, 2);
        check("lat_a_id", a_id_code, 1);
        check("lat_b_valid", b_valid, 1'b0);
        check("lat_count", count, 1);
        step();
        check("lat_count_back", count, 0);
        check("lat_a_idle", a_valid, 1'b0);

        // 3: fill with sinks stalled, fifth opcode held by the producer
        a_ready = 1'b0;
        b_ready = 1'b0;
        d0 = n_delivered;
        for (int i = 0; i < 4; i++) send(i[0], 2'(i), 2'(3 - i), 9'(10 + i), 9'(50 + i));
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 1'b0);
        in_sel = 1'b1; in_addr = 2'd3; in_id_code = 2'd2; in_x = 9'd14; in_y = 9'd54;
        in_valid = 1'b1;
        step(); step(); step();
        check("held_count", count, 4);
        check("held_in_ready", in_ready, 1'b0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        wait_accept("fifth");
        drain("fill");
        check("fill_delivered", n_delivered - d0, 5);

        // 4: A,B,A with A stalled; B must wait behind the first A
        a_ready = 1'b0;
        b_ready = 1'b1;
        send(1'b0, 2'd0, 2'd0, 9'd1, 9'd0);
        send(1'b1, 2'd1, 2'd1, 9'd2, 9'd0);
        send(1'b0, 2'd2, 2'd2, 9'd3, 9'd0);
        step(); step();
        check("order_count", count, 3);
        check("order_b_blocked", b_valid, 1'b0);
        check("order_a_head", a_x, 1);
        a_ready = 1'b1;
        drain("order");

        // 5: start full, stream 10 more through while A drains
        a_ready = 1'b0;
        d0 = n_delivered;
        for (int i = 0; i < 4; i++) send(1'b0, 2'(i), 2'(i), 9'(20 + i), 9'(300 + i));
        check("wrap_full", count, 4);
        a_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(1'b0, 2'(i), 2'(i + 1), 9'(30 + i), 9'(400 + i));
        check("wrap_steady_count", count, 3);
        drain("wrap");
        check("wrap_delivered", n_delivered - d0, 14);

        // 6: reset with three entries stored, then normal traffic
        a_ready = 1'b0;
        b_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 2'(i), 2'(i), 9'(60 + i), 9'(70 + i));
        check("mid_count", count, 3);
        reset = 1'b1;
        sb_q.delete();
        step();
        check("mid_rst_count", count, 0);
        check("mid_rst_valids", {a_valid, b_valid}, 2'b00);
        check("mid_rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_rel_in_ready", in_ready, 1'b1);
        a_ready = 1'b1;
        b_ready = 1'b1;
        d0 = n_delivered;
        send(1'b0, 2'd1, 2'd3, 9'd7, 9'd17);
        send(1'b1, 2'd2, 2'd0, 9'd8, 9'd18);
        drain("after_rst");
        check("after_rst_delivered", n_delivered - d0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
